// File: rtl/rr_req_queue.sv
`default_nettype none
// ============================================================================
//  Module   : rr_req_queue
//  Purpose  : Per-requester FIFOs feeding a round-robin arbiter, with a single
//             registered valid/ready output stage popped by the one-hot grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_req_queue #(
    parameter int N     = 3,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    push_valid_i,
    input  logic [N*DW-1:0] push_data_i,
    output logic [N-1:0]    push_ready_o,
    output logic [N-1:0]    req_o,
    input  logic [N-1:0]    grant_i,
    output logic            out_valid_o,
    output logic [DW-1:0]   out_data_o,
    output logic [N-1:0]    out_src_o,
    input  logic            out_ready_i,
    output logic            grant_err_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic          w_take;
    logic          w_onehot;
    logic          w_err;
    logic [N-1:0]  w_pop;
    logic [DW-1:0] w_head [N];
    logic [DW-1:0] w_pop_data;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [N-1:0]  out_src_q,   out_src_d;
    logic          grant_err_q, grant_err_d;

    // Requests are withheld while the output slot is stuck, so the arbiter
    // only rotates on grants that really move a word.
    assign w_take   = ~out_valid_q | out_ready_i;
    assign w_onehot = $onehot(grant_i);
    assign w_err    = (grant_i != '0) & (~w_onehot | ((grant_i & ~req_o) != '0));

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            logic [DW-1:0]      mem_q [DEPTH];
            logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [c_CNT_W-1:0] cnt_q,    cnt_d;
            logic               w_push;

            assign push_ready_o[i] = (cnt_q != c_CNT_W'(DEPTH));
            assign req_o[i]        = (cnt_q != '0) & w_take;
            assign w_pop[i]        = grant_i[i] & req_o[i] & w_onehot;
            assign w_push          = push_valid_i[i] & push_ready_o[i];
            assign w_head[i]       = mem_q[rd_ptr_q];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                if (w_push) begin
                    wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
                end
                if (w_pop[i]) begin
                    rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
                end
                if (w_push && !w_pop[i]) begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end else if (!w_push && w_pop[i]) begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push) begin
                    mem_q[wr_ptr_q] <= push_data_i[i*DW +: DW];
                end
            end
        end
    endgenerate

    always_comb begin
        w_pop_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pop[i]) begin
                w_pop_data = w_pop_data | w_head[i];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        grant_err_d = grant_err_q | w_err;
        if (w_pop != '0) begin
            out_valid_d = 1'b1;
            out_data_d  = w_pop_data;
            out_src_d   = w_pop;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            grant_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign grant_err_o = grant_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_req_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_req_queue
//  Purpose  : Directed bench for rr_req_queue with a behavioural round-robin
//             arbiter attached; grant can be overridden for error cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_req_queue;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [N-1:0]    pv;
        logic [N*DW-1:0] pd;
        logic            ordy;
        logic            gate;
        logic [N-1:0]    e_req;
        logic            e_ov;
        logic [DW-1:0]   e_od;
        logic [N-1:0]    e_src;
        logic [N-1:0]    e_pr;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    push_valid;
    logic [N*DW-1:0] push_data;
    logic [N-1:0]    push_ready;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    out_src;
    logic            out_ready;
    logic            grant_err;

    logic            force_en;
    logic [N-1:0]    force_grant;
    logic [N-1:0]    arb_grant;
    int              arb_last;
    int              arb_idx;

    int              checks = 0;
    int              errors = 0;
    logic [DW-1:0]   got   [$];
    logic [DW-1:0]   exp_q [$];
    vec_t            tbl   [13];

    always #5 clk = ~clk;

    rr_req_queue #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (push_valid),
        .push_data_i  (push_data),
        .push_ready_o (push_ready),
        .req_o        (req),
        .grant_i      (grant),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_src_o    (out_src),
        .out_ready_i  (out_ready),
        .grant_err_o  (grant_err)
    );

    // Round-robin arbiter: search starts one past the last granted lane.
    always_comb begin
        arb_grant = '0;
        arb_idx   = arb_last;
        for (int k = 1; k <= N; k++) begin
            if (arb_grant == '0 && req[(arb_last + k) % N]) begin
                arb_grant[(arb_last + k) % N] = 1'b1;
                arb_idx = (arb_last + k) % N;
            end
        end
    end

    assign grant = force_en ? force_grant : arb_grant;

    always @(posedge clk) begin
        if (rst) begin
            arb_last <= N - 1;
        end else if (!force_en && arb_grant != '0) begin
            arb_last <= arb_idx;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic collect(input int ncyc);
        got.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(out_data);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp_got(input string nm);
        chk({nm, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_word%0d", nm, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        //          pv      pd           ordy  gate  req     ov    od     src     pr
        tbl[0]  = '{3'b001, 24'h0000A1, 1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 3'b000, 3'b111};
        tbl[1]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b001, 1'b0, 8'h00, 3'b000, 3'b111};
        tbl[2]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 1'b1, 8'hA1, 3'b001, 3'b111};
        tbl[3]  = '{3'b111, 24'h302010, 1'b1, 1'b1, 3'b000, 1'b0, 8'hA1, 3'b001, 3'b111};
        tbl[4]  = '{3'b111, 24'h312111, 1'b1, 1'b1, 3'b111, 1'b0, 8'hA1, 3'b001, 3'b111};
        tbl[5]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b111, 1'b0, 8'hA1, 3'b001, 3'b111};
        tbl[6]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b111, 1'b1, 8'h20, 3'b010, 3'b111};
        tbl[7]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b111, 1'b1, 8'h30, 3'b100, 3'b111};
        tbl[8]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b111, 1'b1, 8'h10, 3'b001, 3'b111};
        tbl[9]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b101, 1'b1, 8'h21, 3'b010, 3'b111};
        tbl[10] = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b001, 1'b1, 8'h31, 3'b100, 3'b111};
        tbl[11] = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 1'b1, 8'h11, 3'b001, 3'b111};
        tbl[12] = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 1'b0, 8'h11, 3'b001, 3'b111};

        rst         = 1'b1;
        push_valid  = '0;
        push_data   = '0;
        out_ready   = 1'b1;
        force_en    = 1'b0;
        force_grant = '0;
        nxt();
        nxt();
        rst = 1'b0;
        mid();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {24'h0, out_data}, 32'h0);
        chk("rst_out_src", {29'h0, out_src}, 32'h0);
        chk("rst_grant_err", {31'h0, grant_err}, 32'h0);
        chk("rst_push_ready", {29'h0, push_ready}, 32'h7);
        chk("rst_req", {29'h0, req}, 32'h0);
        nxt();

        // Single push latency, then three-lane rotation with no bubbles.
        for (int r = 0; r < 13; r++) begin
            push_valid  = tbl[r].pv;
            push_data   = tbl[r].pd;
            out_ready   = tbl[r].ordy;
            force_en    = tbl[r].gate;
            force_grant = '0;
            mid();
            chk($sformatf("row%0d_req", r), {29'h0, req}, {29'h0, tbl[r].e_req});
            chk($sformatf("row%0d_out_valid", r), {31'h0, out_valid}, {31'h0, tbl[r].e_ov});
            chk($sformatf("row%0d_out_data", r), {24'h0, out_data}, {24'h0, tbl[r].e_od});
            chk($sformatf("row%0d_out_src", r), {29'h0, out_src}, {29'h0, tbl[r].e_src});
            chk($sformatf("row%0d_push_ready", r), {29'h0, push_ready}, {29'h0, tbl[r].e_pr});
            nxt();
        end

        // Fill lane 2, refuse extra pushes (also while popping), drain in order.
        out_ready   = 1'b0;
        force_en    = 1'b1;
        force_grant = '0;
        for (int k = 0; k < 4; k++) begin
            push_valid = 3'b100;
            push_data  = {8'(32'hB0 + k), 16'h0000};
            mid();
            chk($sformatf("fill%0d_push_ready", k), {29'h0, push_ready}, 32'h7);
            nxt();
        end
        push_data = 24'hB40000;
        mid();
        chk("full_push_ready", {29'h0, push_ready}, 32'h3);
        nxt();
        force_en  = 1'b0;
        out_ready = 1'b1;
        push_data = 24'hB50000;
        mid();
        chk("full_pop_push_ready", {29'h0, push_ready}, 32'h3);
        chk("full_pop_req", {29'h0, req}, 32'h4);
        nxt();
        push_valid = '0;
        collect(7);
        exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        cmp_got("drain_lane2");

        // Stalled output holds data and blocks requests; rotation resumes after.
        force_en   = 1'b1;
        push_valid = 3'b111;
        push_data  = 24'h605040;
        nxt();
        push_data  = 24'h615141;
        nxt();
        push_valid = '0;
        force_en   = 1'b0;
        out_ready  = 1'b0;
        mid();
        chk("stall_pre_req", {29'h0, req}, 32'h7);
        chk("stall_pre_out_valid", {31'h0, out_valid}, 32'h0);
        nxt();
        for (int k = 0; k < 5; k++) begin
            mid();
            chk($sformatf("stall%0d_req", k), {29'h0, req}, 32'h0);
            chk($sformatf("stall%0d_out_valid", k), {31'h0, out_valid}, 32'h1);
            chk($sformatf("stall%0d_out_data", k), {24'h0, out_data}, 32'h40);
            nxt();
        end
        out_ready = 1'b1;
        collect(8);
        exp_q = '{8'h40, 8'h50, 8'h60, 8'h41, 8'h51, 8'h61};
        cmp_got("stall_release");

        // Illegal grants: no pop, sticky error.
        force_en    = 1'b1;
        force_grant = '0;
        push_valid  = 3'b011;
        push_data   = 24'h008070;
        nxt();
        push_valid  = '0;
        force_grant = 3'b011;
        mid();
        chk("multi_grant_req", {29'h0, req}, 32'h3);
        chk("multi_grant_err_before", {31'h0, grant_err}, 32'h0);
        nxt();
        force_grant = 3'b100;
        mid();
        chk("multi_grant_err_after", {31'h0, grant_err}, 32'h1);
        chk("multi_grant_req_after", {29'h0, req}, 32'h3);
        chk("multi_grant_no_pop", {31'h0, out_valid}, 32'h0);
        nxt();
        force_grant = '0;
        mid();
        chk("noreq_grant_req", {29'h0, req}, 32'h3);
        chk("noreq_grant_no_pop", {31'h0, out_valid}, 32'h0);
        chk("noreq_grant_err", {31'h0, grant_err}, 32'h1);
        nxt();
        force_en = 1'b0;
        collect(5);
        exp_q = '{8'h70, 8'h80};
        cmp_got("after_err_drain");
        mid();
        chk("err_sticky", {31'h0, grant_err}, 32'h1);
        nxt();

        // Reset with buffered words and a full output slot discards everything.
        force_en   = 1'b1;
        push_valid = 3'b111;
        push_data  = 24'hC2C1C0;
        nxt();
        push_valid = 3'b001;
        push_data  = 24'h0000C3;
        nxt();
        push_valid = '0;
        force_en   = 1'b0;
        out_ready  = 1'b0;
        mid();
        chk("prerst_req", {29'h0, req}, 32'h7);
        nxt();
        mid();
        chk("prerst_out_valid", {31'h0, out_valid}, 32'h1);
        chk("prerst_out_data", {24'h0, out_data}, 32'hC2);
        chk("prerst_req_blocked", {29'h0, req}, 32'h0);
        chk("prerst_err", {31'h0, grant_err}, 32'h1);
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        mid();
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_out_data", {24'h0, out_data}, 32'h0);
        chk("midrst_out_src", {29'h0, out_src}, 32'h0);
        chk("midrst_req", {29'h0, req}, 32'h0);
        chk("midrst_push_ready", {29'h0, push_ready}, 32'h7);
        chk("midrst_err", {31'h0, grant_err}, 32'h0);
        nxt();
        out_ready = 1'b1;
        mid();
        chk("midrst_fifos_empty", {29'h0, req}, 32'h0);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
